// File: rtl/imem_pkg.sv
// Shared types and defaults for the loadable instruction memory.
// Holds the load FSM state enum, default widths and the default NOP word.
package imem_pkg;

  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_ADDR_W = 5;
  localparam int IMEM_DEPTH  = 32;
  localparam int LEN_W       = IMEM_ADDR_W + 1;

  localparam logic [IMEM_DATA_W-1:0] IMEM_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_loadable_if.sv
// Program-stream and fetch bus of the loadable instruction memory.
// slave: memory side; master: loader/core side.
interface imem_loadable_if
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int ADDR_W = IMEM_ADDR_W
) ();

  logic              prog_start;
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_last;
  logic              prog_busy;
  logic [ADDR_W:0]   image_len;

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic [DATA_W-1:0] instru;
  logic              instr_valid;
  logic              addr_err;

  modport slave (
    input  prog_start,
    input  prog_valid,
    input  prog_data,
    input  prog_last,
    output prog_busy,
    output image_len,
    input  fetch_req,
    input  fetch_addr,
    output fetch_ready,
    output instru,
    output instr_valid,
    output addr_err
  );

  modport master (
    output prog_start,
    output prog_valid,
    output prog_data,
    output prog_last,
    input  prog_busy,
    input  image_len,
    output fetch_req,
    output fetch_addr,
    input  fetch_ready,
    input  instru,
    input  instr_valid,
    input  addr_err
  );

endinterface

// File: rtl/imem_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
// Ports: clk, we/waddr/wdata write side, re/raddr/rdata read side. No reset.
module imem_ram
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: RAM image written via a program stream,
// fetched with one cycle latency. Ports: clk, reset (async, active-high), bus.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int                DATA_W   = IMEM_DATA_W,
  parameter int                ADDR_W   = IMEM_ADDR_W,
  parameter int                DEPTH    = IMEM_DEPTH,
  parameter logic [DATA_W-1:0] NOP_WORD = IMEM_NOP
) (
  input  logic            clk,
  input  logic            reset,
  imem_loadable_if.slave  bus
);

  localparam int LW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  imem_state_e       state, state_n;
  logic [ADDR_W-1:0] wptr, wptr_n;
  logic [LW-1:0]     len, len_n;
  logic              we;

  logic              accept;
  logic              in_range;
  logic              have_res;
  logic              nop_sel;
  logic              valid_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      wptr  <= '0;
      len   <= '0;
    end else begin
      state <= state_n;
      wptr  <= wptr_n;
      len   <= len_n;
    end
  end

  // A restart in LOAD discards the partial image by rewinding wptr only;
  // len keeps describing the last completed image until the new one ends.
  always_comb begin
    state_n = state;
    wptr_n  = wptr;
    len_n   = len;
    we      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (bus.prog_start) begin
          state_n = LOAD;
          wptr_n  = '0;
        end
      end
      LOAD: begin
        if (bus.prog_start) begin
          wptr_n = '0;
        end else if (bus.prog_valid) begin
          we = 1'b1;
          if (bus.prog_last || wptr == LAST_PTR) begin
            state_n = READY;
            len_n   = LW'(wptr) + LW'(1);
            wptr_n  = '0;
          end else begin
            wptr_n = wptr + ADDR_W'(1);
          end
        end
      end
      READY: begin
        if (bus.prog_start) begin
          state_n = LOAD;
          wptr_n  = '0;
        end
      end
      default: begin
        state_n = EMPTY;
        wptr_n  = '0;
      end
    endcase
  end

  assign bus.fetch_ready = (state == READY) && !bus.prog_start;
  assign accept          = bus.fetch_req && bus.fetch_ready;
  assign in_range        = {1'b0, bus.fetch_addr} < len;

  imem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr),
    .wdata (bus.prog_data),
    .re    (accept && in_range),
    .raddr (bus.fetch_addr),
    .rdata (rdata)
  );

  // The RAM read register only updates on in-range fetches, so a NOP
  // select flag plus a "has any result" flag reproduce a resettable,
  // holding output register without resetting the RAM itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_res <= 1'b0;
      nop_sel  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= accept;
      err_q   <= accept && !in_range;
      if (accept) begin
        have_res <= 1'b1;
        nop_sel  <= !in_range;
      end
    end
  end

  always_comb begin
    bus.instru = '0;
    if (have_res)
      bus.instru = nop_sel ? NOP_WORD : rdata;
  end

  assign bus.instr_valid = valid_q;
  assign bus.addr_err    = err_q;
  assign bus.prog_busy   = (state == LOAD);
  assign bus.image_len   = len;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed self-checking bench for imem_loadable.
// Drives on the falling edge, samples on the falling edge.
module tb_imem_loadable;

  logic clk = 1'b0;
  logic reset;
  int   ncmp = 0;
  int   nerr = 0;

  imem_loadable_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  imem_loadable #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .DEPTH    (32),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] img [32];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.prog_start = 1'b0;
    bus.prog_valid = 1'b0;
    bus.prog_data  = '0;
    bus.prog_last  = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
  endtask

  task automatic start();
    bus.prog_start = 1'b1;
    @(negedge clk);
    bus.prog_start = 1'b0;
    chk("busy_after_start", 32'(bus.prog_busy), 32'd1);
  endtask

  // Streams img[0..n-1]; ends at the falling edge after the final write.
  task automatic stream(input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      bus.prog_valid = 1'b1;
      bus.prog_data  = img[i];
      bus.prog_last  = last && (i == n - 1);
      @(negedge clk);
    end
    bus.prog_valid = 1'b0;
    bus.prog_last  = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [4:0] a,
                       input logic [31:0] exp, input bit err);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    @(negedge clk);
    bus.fetch_req  = 1'b0;
    chk({tag, "_v"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, "_d"}, bus.instru, exp);
    chk({tag, "_e"}, 32'(bus.addr_err), 32'(err));
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_busy", 32'(bus.prog_busy), 32'd0);
    chk("rst_len", 32'(bus.image_len), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instru", bus.instru, 32'd0);
    chk("rst_err", 32'(bus.addr_err), 32'd0);

    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 5'd0;
    #1 chk("empty_rdy", 32'(bus.fetch_ready), 32'd0);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    chk("empty_valid", 32'(bus.instr_valid), 32'd0);

    img[0] = 32'hAC23_0000;
    img[1] = 32'h8C3F_0000;
    img[2] = 32'hFC00_0000;
    img[3] = 32'hF800_0002;
    img[4] = 32'h8C01_1860;
    start();
    stream(5, 1'b1);
    chk("l5_busy", 32'(bus.prog_busy), 32'd0);
    chk("l5_len", 32'(bus.image_len), 32'd5);
    chk("l5_rdy", 32'(bus.fetch_ready), 32'd1);

    fetch("f0", 5'd0, 32'hAC23_0000, 1'b0);
    fetch("f1", 5'd1, 32'h8C3F_0000, 1'b0);
    fetch("f2", 5'd2, 32'hFC00_0000, 1'b0);
    fetch("f3", 5'd3, 32'hF800_0002, 1'b0);
    fetch("f4", 5'd4, 32'h8C01_1860, 1'b0);
    @(negedge clk);
    chk("hold_valid", 32'(bus.instr_valid), 32'd0);
    chk("hold_data", bus.instru, 32'h8C01_1860);

    fetch("f7", 5'd7, 32'h0000_0000, 1'b1);
    @(negedge clk);
    chk("f7_errpulse", 32'(bus.addr_err), 32'd0);
    chk("f7_hold", bus.instru, 32'h0000_0000);
    fetch("f5", 5'd5, 32'h0000_0000, 1'b1);
    fetch("f4b", 5'd4, 32'h8C01_1860, 1'b0);

    for (int i = 0; i < 32; i++)
      img[i] = 32'h5000_0000 | (i << 8) | i;
    start();
    stream(32, 1'b0);
    chk("l32_busy", 32'(bus.prog_busy), 32'd0);
    chk("l32_len", 32'(bus.image_len), 32'd32);
    fetch("f31", 5'd31, 32'h5000_1F1F, 1'b0);
    fetch("f0b", 5'd0, 32'h5000_0000, 1'b0);

    bus.prog_start = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 5'd1;
    #1 chk("race_rdy", 32'(bus.fetch_ready), 32'd0);
    @(negedge clk);
    bus.prog_start = 1'b0;
    bus.fetch_req  = 1'b0;
    chk("race_valid", 32'(bus.instr_valid), 32'd0);
    chk("race_busy", 32'(bus.prog_busy), 32'd1);
    img[0] = 32'hDEAD_0001;
    img[1] = 32'hDEAD_0002;
    stream(2, 1'b0);
    chk("mid_len", 32'(bus.image_len), 32'd32);
    start();
    img[0] = 32'h1111_0000;
    img[1] = 32'h2222_0001;
    img[2] = 32'h3333_0002;
    stream(3, 1'b1);
    chk("l3_len", 32'(bus.image_len), 32'd3);
    fetch("r0", 5'd0, 32'h1111_0000, 1'b0);
    fetch("r2", 5'd2, 32'h3333_0002, 1'b0);
    fetch("r3", 5'd3, 32'h0000_0000, 1'b1);

    img[0] = 32'hCAFE_0000;
    img[1] = 32'hCAFE_0001;
    start();
    stream(2, 1'b0);
    chk("pre_rst_busy", 32'(bus.prog_busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.prog_busy), 32'd0);
    chk("arst_len", 32'(bus.image_len), 32'd0);
    chk("arst_rdy", 32'(bus.fetch_ready), 32'd0);
    chk("arst_valid", 32'(bus.instr_valid), 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 5'd0;
    #1 chk("post_rst_rdy", 32'(bus.fetch_ready), 32'd0);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    chk("post_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("post_rst_instru", bus.instru, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised instruction memory for the single-cycle core. It replaces a fixed, reset-initialised ROM with a RAM image written through a streaming program port. Fetches are gated by a load state machine and read back with one registered cycle of latency. Addresses beyond the loaded image return a NOP word and raise an error pulse; they never return stale contents.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits
- ADDR_W, 5, fetch/program address width
- DEPTH, 32, number of words; DEPTH ≤ 2**ADDR_W
- NOP_WORD, 32'h0000_0000, word returned for out-of-image fetches

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- reset  in  1  asynchronous, active-high
- prog_start  in  1  one-cycle pulse; begins a new image load at address 0
- prog_valid  in  1  prog_data is valid this cycle
- prog_data  in  DATA_W  instruction word to store
- prog_last  in  1  qualifies prog_valid; marks the final word of the image
- prog_busy  out  1  high while state is LOAD
- image_len  out  ADDR_W+1  number of words in the last completed image
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  word address to fetch
- fetch_ready  out  1  combinational; high = (state==READY) && !prog_start
- instru  out  DATA_W  fetched word, registered
- instr_valid  out  1  instru holds a fetch result this cycle
- addr_err  out  1  one-cycle pulse alongside instr_valid for an out-of-image fetch

## Operation
- States: EMPTY, LOAD, READY.
- Reset values: state=EMPTY, wptr=0, image_len=0, instru=0, instr_valid=0, addr_err=0, prog_busy=0. The RAM array is not reset.
- EMPTY → LOAD on prog_start.
- LOAD: each prog_valid writes prog_data at wptr and increments wptr.
  - LOAD → READY on a write with prog_last=1, or on the write at wptr==DEPTH-1.
  - On that exit, image_len = wptr+1 and wptr returns to 0.
  - prog_valid outside LOAD is ignored.
- prog_start in LOAD restarts at wptr=0 and stays in LOAD. Words already written are discarded logically: image_len is unchanged until the load completes.
- prog_start in READY → LOAD; image_len keeps its old value until the new load completes.
- Fetch is accepted when fetch_req && fetch_ready.
  - If fetch_addr < image_len, instru = RAM[fetch_addr] next cycle.
  - Otherwise instru = NOP_WORD and addr_err=1 next cycle.
- A fetch not accepted gives instr_valid=0 next cycle. instru then holds its previous value.
- prog_start in the same cycle as fetch_req: load wins and the fetch is refused, because fetch_ready is low.
- Width rule: compare fetch_addr zero-extended to ADDR_W+1 bits against image_len.
- Write-and-read of the same address cannot happen, since fetches never occur in LOAD.

## Timing
- Fetch latency: 1 cycle, request cycle N → instru/instr_valid at N+1.
- Back-to-back fetches give one result per cycle.
- Program throughput: one word per cycle.
- Load-to-fetch turnaround:
  - The final write at cycle N makes state READY at N+1.
  - A fetch can be accepted at N+1 and returns the new word at N+2.
- prog_busy rises the cycle after prog_start and falls the cycle after the final write.
- Asynchronous reset mid-load: back to EMPTY immediately. image_len=0, so all later fetches are refused until a new load completes.

## Structure
- Shared package imem_pkg holds:
  - the state enum (EMPTY, LOAD, READY)
  - the default NOP constant
  - localparam LEN_W = ADDR_W+1
- Sub-module imem_ram: simple dual-port RAM, DEPTH×DATA_W.
  - Synchronous write port; synchronous registered read port.
  - No reset; this keeps the array inferable as block/distributed RAM.
- Top level holds the FSM, wptr, image_len, the range compare and the output registers.

## Test plan
- After reset, fetch_req=1 to addr 0 → fetch_ready=0, instr_valid stays 0, prog_busy=0, image_len=0.
- Load 5 words (0xAC230000, 0x8C3F0000, 0xFC000000, 0xF8000002, 0x8C011860), prog_last on the 5th → image_len=5, READY. Fetch addrs 0..4 back-to-back → instru matches each word 1 cycle later.
- Fetch addr 7 with image_len=5 → instru=0x00000000, addr_err=1 for exactly one cycle.
- Load 32 words without prog_last → auto-exit at word 31, image_len=32. Fetch addr 31 returns the last word.
- prog_start and fetch_req in the same cycle while READY → fetch refused (no instr_valid). Then a mid-load prog_start restarts at 0, and after 3 words with prog_last, image_len=3.
- Assert reset during LOAD after 2 writes → state EMPTY, image_len=0, prog_busy=0 asynchronously, before the next clock edge.
